// File: rtl/memory_register_pkg.sv
// Shared widths and types for the 32x32 register file.
package memory_register_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DEPTH  = 2 ** ADDR_W;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] addr_t;

endpackage

// File: rtl/memory_register_wdec.sv
// One-hot write-enable decoder; MEMORY_REGISTER_ZERO_REG_EN masks entry 0.
module memory_register_wdec
  import memory_register_pkg::*;
(
  input  logic [ADDR_W-1:0] writereg_i,
  input  logic              regwrite_i,
  input  logic              clr_i,
  output logic [DEPTH-1:0]  we_o
);

  always_comb begin
    we_o = '0;
    if (regwrite_i && !clr_i) begin
      we_o[writereg_i] = 1'b1;
    end
`ifdef MEMORY_REGISTER_ZERO_REG_EN
    we_o[0] = 1'b0;
`endif
  end

endmodule

// File: rtl/memory_register.sv
// 32x32 register file: two combinational read ports, one synchronous write port,
// async active-high clear. MEMORY_REGISTER_ZERO_REG_EN hardwires register 0 to zero.
module memory_register
  import memory_register_pkg::*;
(
  input  logic              clk,
  input  logic              clr,
  input  logic [ADDR_W-1:0] readreg1,
  input  logic [ADDR_W-1:0] readreg2,
  input  logic [ADDR_W-1:0] writereg,
  input  logic [DATA_W-1:0] data,
  input  logic              regwrite,
  output logic [DATA_W-1:0] read1,
  output logic [DATA_W-1:0] read2
);

  logic [DEPTH-1:0] we;
  word_t            regs_q [DEPTH];

  memory_register_wdec u_wdec (
    .writereg_i (writereg),
    .regwrite_i (regwrite),
    .clr_i      (clr),
    .we_o       (we)
  );

  // Storage array; clear wins over any write.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (we[i]) begin
          regs_q[i] <= data;
        end
      end
    end
  end

  // Read ports are unbypassed: a same-edge write shows up only after the edge.
  always_comb begin
    read1 = regs_q[readreg1];
`ifdef MEMORY_REGISTER_ZERO_REG_EN
    if (readreg1 == '0) begin
      read1 = '0;
    end
`endif
  end

  always_comb begin
    read2 = regs_q[readreg2];
`ifdef MEMORY_REGISTER_ZERO_REG_EN
    if (readreg2 == '0) begin
      read2 = '0;
    end
`endif
  end

endmodule

// File: tb/tb_memory_register.sv
// Self-checking bench for memory_register: directed cases plus random traffic
// against an array model; honours MEMORY_REGISTER_ZERO_REG_EN.
`timescale 1ns/1ps
module tb_memory_register;

  logic        clk = 1'b0;
  logic        clr;
  logic [4:0]  readreg1, readreg2, writereg;
  logic [31:0] data;
  logic        regwrite;
  logic [31:0] read1, read2;

  logic [31:0] model [32] = '{default: 32'h0};
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  memory_register dut (
    .clk      (clk),
    .clr      (clr),
    .readreg1 (readreg1),
    .readreg2 (readreg2),
    .writereg (writereg),
    .data     (data),
    .regwrite (regwrite),
    .read1    (read1),
    .read2    (read2)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] expect_rd(input logic [4:0] a);
`ifdef MEMORY_REGISTER_ZERO_REG_EN
    if (a == 5'd0) return 32'h0;
`endif
    return model[a];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: clear empties everything, a clean enabled edge stores data.
  always @(posedge clr) model = '{default: 32'h0};
  always @(posedge clk) begin
    if (clr !== 1'b1 && regwrite === 1'b1) model[writereg] = data;
  end

  // Continuous compare away from the active edge.
  always @(negedge clk) begin
    check("cmp_read1", read1, expect_rd(readreg1));
    check("cmp_read2", read2, expect_rd(readreg2));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    regwrite = 1'b1; writereg = a; data = d;
    step();
    regwrite = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    for (int i = 0; i < 32; i++) begin
      readreg1 = 5'(i);
      readreg2 = 5'(31 - i);
      #0.005;
      check(name, read1, 32'h0);
      check(name, read2, 32'h0);
    end
  endtask

  initial begin
    clr = 1'b1; regwrite = 1'b0; writereg = '0; data = '0;
    readreg1 = '0; readreg2 = '0;
    #1;
    check_all_zero("reset_zero");
    step();
    clr = 1'b0;
    step();

    // Basic write then read.
    wr(5'd5, 32'hDEADBEEF);
    readreg1 = 5'd5;
    #1;
    check("wr_rd_5", read1, 32'hDEADBEEF);

    // Disabled write leaves entry untouched.
    regwrite = 1'b0; writereg = 5'd7; data = 32'h12345678;
    step();
    readreg1 = 5'd7;
    #1;
    check("wr_dis_7", read1, 32'h0);

    // Dual independent reads.
    wr(5'd3, 32'hA5A5A5A5);
    wr(5'd31, 32'h0000FFFF);
    readreg1 = 5'd3; readreg2 = 5'd31;
    #1;
    check("dual_r1", read1, 32'hA5A5A5A5);
    check("dual_r2", read2, 32'h0000FFFF);
    readreg1 = 5'd31;
    #1;
    check("same_r1", read1, 32'h0000FFFF);
    check("same_r2", read2, 32'h0000FFFF);

    // Same-edge write/read: old value before the edge, new after.
    wr(5'd9, 32'h00000077);
    readreg2 = 5'd9;
    regwrite = 1'b1; writereg = 5'd9; data = 32'h1;
    @(negedge clk);
    #1;
    check("sameedge_old", read2, 32'h00000077);
    step();
    regwrite = 1'b0;
    check("sameedge_new", read2, 32'h1);

    // Register 0 behaviour.
    wr(5'd0, 32'hCAFEF00D);
    readreg1 = 5'd0;
    #1;
`ifdef MEMORY_REGISTER_ZERO_REG_EN
    check("reg0_hard", read1, 32'h0);
`else
    check("reg0_rw", read1, 32'hCAFEF00D);
`endif

    // Mid-cycle asynchronous clear, with a write pending that must be blocked.
    regwrite = 1'b1; writereg = 5'd12; data = 32'h55AA55AA;
    clr = 1'b1;
    check_all_zero("clr_zero");
    step();
    clr = 1'b0; regwrite = 1'b0;
    readreg1 = 5'd12;
    #1;
    check("clr_blk_wr", read1, 32'h0);
    step();

    // Random traffic; writereg biased towards register 0.
    for (int c = 0; c < 300; c++) begin
      readreg1 = 5'($urandom_range(31));
      readreg2 = ($urandom_range(3) == 0) ? readreg1 : 5'($urandom_range(31));
      writereg = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(31));
      data     = $urandom;
      regwrite = 1'($urandom_range(1));
      step();
    end
    regwrite = 1'b0;
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
